// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling: 2-flop line synchronizer,
// mid-bit sampling FSM, registered done / frame-error strobes.
module uart_rx #(
  parameter int unsigned NB_DATA = 8,
  parameter int unsigned SB_TICK = 16,
  parameter int unsigned NB_TICK = 4,
  parameter int unsigned NB_BITS = 3
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_tick,
  input  logic               i_rx,
  output logic [NB_DATA-1:0] o_data,
  output logic               o_rx_done,
  output logic               o_frame_error
);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_e;

  localparam logic [NB_TICK-1:0] MID_TICK  = NB_TICK'(7);
  localparam logic [NB_TICK-1:0] LAST_TICK = NB_TICK'(15);
  localparam logic [NB_TICK-1:0] STOP_TICK = NB_TICK'(SB_TICK - 1);
  localparam logic [NB_BITS-1:0] LAST_BIT  = NB_BITS'(NB_DATA - 1);

  state_e               state_q, state_d;
  logic                 rx_meta_q, rx_s_q;
  logic [NB_TICK-1:0]   s_q, s_d;
  logic [NB_BITS-1:0]   n_q, n_d;
  logic [NB_DATA-1:0]   b_q, b_d;
  logic [NB_DATA-1:0]   data_q, data_d;
  logic                 done_q, done_d;
  logic                 ferr_q, ferr_d;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q   <= IDLE;
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      s_q       <= '0;
      n_q       <= '0;
      b_q       <= '0;
      data_q    <= '0;
      done_q    <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rx_meta_q <= i_rx;
      rx_s_q    <= rx_meta_q;
      s_q       <= s_d;
      n_q       <= n_d;
      b_q       <= b_d;
      data_q    <= data_d;
      done_q    <= done_d;
      ferr_q    <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    data_d  = data_q;
    done_d  = 1'b0;
    ferr_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Start edge is taken on any clock, not only on a tick.
        if (!rx_s_q) begin
          s_d     = '0;
          state_d = START;
        end
      end
      START: begin
        if (i_tick) begin
          if (s_q == MID_TICK) begin
            if (!rx_s_q) begin
              s_d     = '0;
              n_d     = '0;
              state_d = DATA;
            end else begin
              state_d = IDLE;
            end
          end else begin
            s_d = s_q + NB_TICK'(1);
          end
        end
      end
      DATA: begin
        if (i_tick) begin
          if (s_q == LAST_TICK) begin
            s_d = '0;
            b_d = {rx_s_q, b_q[NB_DATA-1:1]};
            if (n_q == LAST_BIT) begin
              state_d = STOP;
            end else begin
              n_d = n_q + NB_BITS'(1);
            end
          end else begin
            s_d = s_q + NB_TICK'(1);
          end
        end
      end
      STOP: begin
        if (i_tick) begin
          if (s_q == STOP_TICK) begin
            if (rx_s_q) begin
              data_d = b_q;
              done_d = 1'b1;
            end else begin
              ferr_d = 1'b1;
            end
            state_d = IDLE;
          end else begin
            s_d = s_q + NB_TICK'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_data        = data_q;
  assign o_rx_done     = done_q;
  assign o_frame_error = ferr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx: frames are driven on tick boundaries, expected
// strobes go to a scoreboard queue, a monitor pops them as strobes appear.
module tb_uart_rx;

  typedef struct packed {
    logic       err;
    logic [7:0] data;
  } exp_t;

  logic       clk;
  logic       i_reset;
  logic       i_tick;
  logic       i_rx;
  logic [7:0] o_data;
  logic       o_rx_done;
  logic       o_frame_error;

  int          checks    = 0;
  int          failures  = 0;
  int          n_done    = 0;
  int          n_err     = 0;
  longint      cyc       = 0;
  longint      start_cyc = 0;
  longint      done_cyc  = 0;
  bit          tick_all  = 1'b0;
  bit          mon_en    = 1'b0;
  logic [7:0]  exp_data  = 8'h00;
  exp_t        exp_q[$];

  uart_rx #(
    .NB_DATA(8),
    .SB_TICK(16),
    .NB_TICK(4),
    .NB_BITS(3)
  ) dut (
    .i_clock      (clk),
    .i_reset      (i_reset),
    .i_tick       (i_tick),
    .i_rx         (i_rx),
    .o_data       (o_data),
    .o_rx_done    (o_rx_done),
    .o_frame_error(o_frame_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One tick every 16 clocks, or every clock when tick_all is set.
  initial begin
    int unsigned tick_cnt;
    tick_cnt = 0;
    i_tick   = 1'b0;
    forever begin
      @(negedge clk);
      if (tick_all) begin
        i_tick = 1'b1;
      end else begin
        i_tick   = (tick_cnt == 15);
        tick_cnt = (tick_cnt + 1) % 16;
      end
    end
  end

  // Scoreboard monitor: every strobe must match the head of the queue.
  initial begin
    logic [7:0] last_data;
    logic       prev_strobe;
    logic       rst_edge;
    exp_t       e;
    last_data   = 8'h00;
    prev_strobe = 1'b0;
    forever begin
      @(posedge clk);
      cyc++;
      rst_edge = i_reset;
      @(negedge clk);
      if (mon_en) begin
        if (o_rx_done === 1'b1 || o_frame_error === 1'b1) begin
          checks++;
          if (o_rx_done === 1'b1 && o_frame_error === 1'b1) begin
            failures++;
            $display("FAIL strobe_overlap: done=%b ferr=%b required not both high", o_rx_done, o_frame_error);
          end
          checks++;
          if (prev_strobe) begin
            failures++;
            $display("FAIL strobe_width: strobe high in consecutive cycles, required single cycle");
          end
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_strobe: done=%b ferr=%b data=%h, required no strobe", o_rx_done, o_frame_error, o_data);
          end else begin
            e = exp_q.pop_front();
            if (o_frame_error !== e.err || o_data !== e.data) begin
              failures++;
              $display("FAIL strobe_data: got ferr=%b data=%h, required ferr=%b data=%h", o_frame_error, o_data, e.err, e.data);
            end
          end
          if (o_rx_done === 1'b1) begin
            n_done++;
            done_cyc = cyc;
          end else begin
            n_err++;
          end
        end
        checks++;
        if (!rst_edge && o_rx_done !== 1'b1 && o_data !== last_data) begin
          failures++;
          $display("FAIL data_stable: o_data changed %h -> %h without o_rx_done", last_data, o_data);
        end
      end
      last_data   = o_data;
      prev_strobe = (o_rx_done === 1'b1) || (o_frame_error === 1'b1);
    end
  end

  task automatic wait_ticks(input int n);
    int k;
    k = 0;
    while (k < n) begin
      @(posedge clk);
      if (i_tick) k++;
    end
    @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_ok);
    @(negedge clk);
    if (stop_ok) begin
      exp_q.push_back({1'b0, d});
      exp_data = d;
    end else begin
      exp_q.push_back({1'b1, exp_data});
    end
    i_rx      = 1'b0;
    start_cyc = cyc;
    wait_ticks(16);
    for (int i = 0; i < 8; i++) begin
      i_rx = d[i];
      wait_ticks(16);
    end
    if (stop_ok) begin
      i_rx = 1'b1;
      wait_ticks(16);
    end else begin
      // Stop held low past its sample point, then released mid-bit.
      i_rx = 1'b0;
      wait_ticks(10);
      i_rx = 1'b1;
      wait_ticks(6);
    end
  endtask

  task automatic test_reset();
    i_rx     = 1'b1;
    i_reset  = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (o_data !== 8'h00) begin
      failures++;
      $display("FAIL reset_data: got %h required 00", o_data);
    end
    checks++;
    if (o_rx_done !== 1'b0 || o_frame_error !== 1'b0) begin
      failures++;
      $display("FAIL reset_strobes: got done=%b ferr=%b required 0 0", o_rx_done, o_frame_error);
    end
    i_reset  = 1'b0;
    exp_data = 8'h00;
    mon_en   = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_single();
    int nd0, ne0;
    nd0 = n_done;
    ne0 = n_err;
    send_frame(8'h55, 1'b1);
    for (int i = 0; i < 4000 && exp_q.size() != 0; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL single_timeout: %0d strobes outstanding, required 0", exp_q.size());
    end
    checks++;
    if (n_done - nd0 != 1 || n_err != ne0) begin
      failures++;
      $display("FAIL single_count: got done=%0d err=%0d required 1 0", n_done - nd0, n_err - ne0);
    end
    checks++;
    if (o_data !== 8'h55) begin
      failures++;
      $display("FAIL single_data: got %h required 55", o_data);
    end
  endtask

  task automatic test_back_to_back();
    int nd0;
    nd0 = n_done;
    send_frame(8'h07, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h80, 1'b1);
    for (int i = 0; i < 4000 && exp_q.size() != 0; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL b2b_timeout: %0d strobes outstanding, required 0", exp_q.size());
    end
    checks++;
    if (n_done - nd0 != 3) begin
      failures++;
      $display("FAIL b2b_count: got %0d done pulses required 3", n_done - nd0);
    end
    checks++;
    if (o_data !== 8'h80) begin
      failures++;
      $display("FAIL b2b_data: got %h required 80", o_data);
    end
  endtask

  task automatic test_glitch();
    int nd0, ne0;
    nd0 = n_done;
    ne0 = n_err;
    @(negedge clk);
    i_rx = 1'b0;
    wait_ticks(4);
    i_rx = 1'b1;
    wait_ticks(48);
    checks++;
    if (n_done != nd0 || n_err != ne0) begin
      failures++;
      $display("FAIL glitch_strobes: got done=%0d err=%0d required 0 0", n_done - nd0, n_err - ne0);
    end
    checks++;
    if (o_data !== exp_data) begin
      failures++;
      $display("FAIL glitch_data: got %h required %h", o_data, exp_data);
    end
    send_frame(8'h5A, 1'b1);
    for (int i = 0; i < 4000 && exp_q.size() != 0; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    checks++;
    if (o_data !== 8'h5A || n_done - nd0 != 1) begin
      failures++;
      $display("FAIL glitch_recover: got data=%h done=%0d required 5a 1", o_data, n_done - nd0);
    end
  endtask

  task automatic test_frame_error();
    int nd0, ne0;
    nd0 = n_done;
    ne0 = n_err;
    send_frame(8'h3C, 1'b1);
    send_frame(8'hA3, 1'b0);
    for (int i = 0; i < 4000 && exp_q.size() != 0; i++) @(negedge clk);
    wait_ticks(32);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL ferr_timeout: %0d strobes outstanding, required 0", exp_q.size());
    end
    checks++;
    if (n_err - ne0 != 1 || n_done - nd0 != 1) begin
      failures++;
      $display("FAIL ferr_count: got err=%0d done=%0d required 1 1", n_err - ne0, n_done - nd0);
    end
    checks++;
    if (o_data !== 8'h3C) begin
      failures++;
      $display("FAIL ferr_data: got %h required 3c", o_data);
    end
  endtask

  task automatic test_reset_midframe();
    int nd0, ne0;
    logic [7:0] d;
    d   = 8'h9A;
    nd0 = n_done;
    ne0 = n_err;
    @(negedge clk);
    i_rx = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < 4; i++) begin
      i_rx = d[i];
      wait_ticks(16);
    end
    i_rx = d[4];
    wait_ticks(8);
    i_reset = 1'b1;
    @(negedge clk);
    i_reset  = 1'b0;
    exp_data = 8'h00;
    checks++;
    if (o_data !== 8'h00 || o_rx_done !== 1'b0 || o_frame_error !== 1'b0) begin
      failures++;
      $display("FAIL midreset_outputs: got data=%h done=%b ferr=%b required 00 0 0", o_data, o_rx_done, o_frame_error);
    end
    i_rx = 1'b1;
    wait_ticks(48);
    checks++;
    if (n_done != nd0 || n_err != ne0) begin
      failures++;
      $display("FAIL midreset_strobes: got done=%0d err=%0d required 0 0", n_done - nd0, n_err - ne0);
    end
    send_frame(8'h12, 1'b1);
    for (int i = 0; i < 4000 && exp_q.size() != 0; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    checks++;
    if (o_data !== 8'h12 || n_done - nd0 != 1) begin
      failures++;
      $display("FAIL midreset_next: got data=%h done=%0d required 12 1", o_data, n_done - nd0);
    end
  endtask

  task automatic test_tick_all();
    int nd0;
    tick_all = 1'b1;
    repeat (4) @(negedge clk);
    nd0 = n_done;
    send_frame(8'hC3, 1'b1);
    for (int i = 0; i < 4000 && exp_q.size() != 0; i++) @(negedge clk);
    repeat (4) @(negedge clk);
    checks++;
    if (o_data !== 8'hC3 || n_done - nd0 != 1) begin
      failures++;
      $display("FAIL tickall_data: got data=%h done=%0d required c3 1", o_data, n_done - nd0);
    end
    // 2 sync clocks + 1 detect clock + 152 ticks.
    checks++;
    if (done_cyc - start_cyc != 155) begin
      failures++;
      $display("FAIL tickall_latency: got %0d clocks required 155", done_cyc - start_cyc);
    end
    tick_all = 1'b0;
  endtask

  initial begin
    i_reset = 1'b1;
    i_rx    = 1'b1;
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_error();
    test_reset_midframe();
    test_tick_all();
    repeat (4) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
